// File: rtl/cross_bar.sv
// -----------------------------------------------------------------------------
// cross_bar
//
// Register-based REGS_NUM x REGS_NUM crossbar. Each of REGS_NUM master ports
// issues a read or write request that is routed by the top address bits to
// one of REGS_NUM slave registers held inside this block. Every slave has its
// own round-robin arbiter, so masters addressing different slaves are served
// in the same cycle.
//
// Ports:
//   clk_i     - clock, all state updates on the rising edge
//   reset_i   - asynchronous, active-high reset
//   req_i     - per-master request, held until ack_o is seen
//   cmd_i     - per-master command: 1 = write, 0 = read
//   addr_i    - per-master address; top $clog2(REGS_NUM) bits pick the slave
//   wdata_i   - per-master write data
//   resp_i    - per-master one-cycle strobe consuming pending read data
//   rdata_o   - per-master registered read data
//   ack_o     - per-master registered one-cycle accept pulse
// -----------------------------------------------------------------------------
module cross_bar #(
    parameter int DW       = 32,
    parameter int AW       = 32,
    parameter int REGS_NUM = 4
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic [REGS_NUM-1:0]          req_i,
    input  logic [REGS_NUM-1:0]          cmd_i,
    input  logic [REGS_NUM-1:0][AW-1:0]  addr_i,
    input  logic [REGS_NUM-1:0][DW-1:0]  wdata_i,
    input  logic [REGS_NUM-1:0]          resp_i,
    output logic [REGS_NUM-1:0][DW-1:0]  rdata_o,
    output logic [REGS_NUM-1:0]          ack_o
);

    localparam int SW = $clog2(REGS_NUM);

    // Per-master decode and eligibility
    logic [SW-1:0]       sel       [REGS_NUM];
    logic [REGS_NUM-1:0] eligible;

    // Per-slave arbitration results
    logic [REGS_NUM-1:0] slave_gnt       [REGS_NUM];  // slave_gnt[s][m]
    logic                slave_gnt_valid [REGS_NUM];
    logic [SW-1:0]       slave_gnt_idx   [REGS_NUM];

    // Grant as seen from each master
    logic [REGS_NUM-1:0] master_gnt;

    // State
    logic [DW-1:0] slave_reg [REGS_NUM];
    logic [SW-1:0] ptr_reg   [REGS_NUM];
    logic          done_reg  [REGS_NUM];
    logic          rpend_reg [REGS_NUM];
    logic          ack_reg   [REGS_NUM];
    logic [DW-1:0] rdata_reg [REGS_NUM];

    genvar gi;

    // -------------------------------------------------------------------------
    // Master-side decode: slave index from the top address bits. A master that
    // has already been served (done) or still holds unconsumed read data
    // (rpend) is kept out of arbitration.
    // -------------------------------------------------------------------------
    generate
        for (gi = 0; gi < REGS_NUM; gi++) begin : g_decode
            logic addr_low_unused;

            assign sel[gi]         = addr_i[gi][AW-1 -: SW];
            assign eligible[gi]    = req_i[gi] && !done_reg[gi] && !rpend_reg[gi];
            // Lower address bits carry no meaning inside the crossbar.
            assign addr_low_unused = ^addr_i[gi][AW-SW-1:0];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Per-slave round-robin arbiter and slave register.
    // -------------------------------------------------------------------------
    generate
        for (gi = 0; gi < REGS_NUM; gi++) begin : g_slave
            logic [REGS_NUM-1:0] req_vec;
            logic [REGS_NUM-1:0] gnt_vec;
            logic                gnt_valid;
            logic [SW-1:0]       gnt_idx;
            logic [SW-1:0]       cand;

            always_comb begin
                req_vec = '0;
                for (int m = 0; m < REGS_NUM; m++) begin
                    req_vec[m] = eligible[m] && (sel[m] == SW'(gi));
                end
            end

            // Scan masters starting at the pointer; the SW-bit addition wraps
            // naturally because REGS_NUM is a power of two.
            always_comb begin
                gnt_vec   = '0;
                gnt_valid = 1'b0;
                gnt_idx   = '0;
                cand      = '0;
                for (int i = 0; i < REGS_NUM; i++) begin
                    cand = ptr_reg[gi] + i[SW-1:0];
                    if (!gnt_valid && req_vec[cand]) begin
                        gnt_valid     = 1'b1;
                        gnt_idx       = cand;
                        gnt_vec[cand] = 1'b1;
                    end
                end
            end

            assign slave_gnt[gi]       = gnt_vec;
            assign slave_gnt_valid[gi] = gnt_valid;
            assign slave_gnt_idx[gi]   = gnt_idx;

            always_ff @(posedge clk_i or posedge reset_i) begin
                if (reset_i) begin
                    slave_reg[gi] <= '0;
                    ptr_reg[gi]   <= '0;
                end else if (slave_gnt_valid[gi]) begin
                    // Winner moves to lowest priority for the next round.
                    ptr_reg[gi] <= slave_gnt_idx[gi] + SW'(1);
                    if (cmd_i[slave_gnt_idx[gi]]) begin
                        slave_reg[gi] <= wdata_i[slave_gnt_idx[gi]];
                    end
                end
            end
        end
    endgenerate

    // A master addresses exactly one slave, so at most one bit per column of
    // slave_gnt can be set; OR-ing the columns gives its grant.
    always_comb begin
        master_gnt = '0;
        for (int s = 0; s < REGS_NUM; s++) begin
            master_gnt = master_gnt | slave_gnt[s];
        end
    end

    // -------------------------------------------------------------------------
    // Per-master protocol state and registered outputs.
    // -------------------------------------------------------------------------
    generate
        for (gi = 0; gi < REGS_NUM; gi++) begin : g_master
            always_ff @(posedge clk_i or posedge reset_i) begin
                if (reset_i) begin
                    done_reg[gi]  <= 1'b0;
                    rpend_reg[gi] <= 1'b0;
                    ack_reg[gi]   <= 1'b0;
                    rdata_reg[gi] <= '0;
                end else begin
                    ack_reg[gi] <= master_gnt[gi];

                    // done blocks a second access while req stays high after
                    // the ack; only a dropped req re-arms the master.
                    if (!req_i[gi]) begin
                        done_reg[gi] <= 1'b0;
                    end else if (master_gnt[gi]) begin
                        done_reg[gi] <= 1'b1;
                    end

                    // The slave register is read before any same-edge write;
                    // a grant on this slave excludes a concurrent write anyway.
                    if (master_gnt[gi] && !cmd_i[gi]) begin
                        rpend_reg[gi] <= 1'b1;
                        rdata_reg[gi] <= slave_reg[sel[gi]];
                    end else if (rpend_reg[gi] && resp_i[gi]) begin
                        rpend_reg[gi] <= 1'b0;
                        rdata_reg[gi] <= '0;
                    end
                end
            end

            assign ack_o[gi]   = ack_reg[gi];
            assign rdata_o[gi] = rdata_reg[gi];
        end
    endgenerate

endmodule

// File: tb/tb_cross_bar.sv
module tb_cross_bar;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NM = 4;

    logic                  clk;
    logic                  rst;
    logic [NM-1:0]         req;
    logic [NM-1:0]         cmd;
    logic [NM-1:0][AW-1:0] addr;
    logic [NM-1:0][DW-1:0] wdata;
    logic [NM-1:0]         resp;
    logic [NM-1:0][DW-1:0] rdata;
    logic [NM-1:0]         ack;

    cross_bar #(.DW(DW), .AW(AW), .REGS_NUM(NM)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .req_i   (req),
        .cmd_i   (cmd),
        .addr_i  (addr),
        .wdata_i (wdata),
        .resp_i  (resp),
        .rdata_o (rdata),
        .ack_o   (ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks_cnt = 0;
    int errors_cnt = 0;

    typedef struct {
        int          m;
        int          at;
        bit          rd;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];

    task automatic check_value(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: simultaneous acks are popped in ascending master order.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            for (int m = 0; m < NM; m++) begin
                if (ack[m]) begin
                    if (exp_q.size() == 0) begin
                        e.m = -1; e.at = -1; e.rd = 1'b0; e.data = '0;
                    end else begin
                        e = exp_q.pop_front();
                    end
                    $display("ack master %0d cycle %0d cmd %s rdata 0x%0h", m, cyc,
                             e.rd ? "rd" : "wr", rdata[m]);
                    check_value("ack_master", 128'(m), 128'(e.m));
                    check_value("ack_cycle", 128'(cyc), 128'(e.at));
                    if (e.rd) check_value("read_data", 128'(rdata[m]), 128'(e.data));
                end
            end
        end
    end

    task automatic drive(input int m, input bit wr, input int s, input logic [31:0] d);
        req[m]   = 1'b1;
        cmd[m]   = wr;
        addr[m]  = {2'(s), 30'($urandom)};
        wdata[m] = d;
    endtask

    task automatic expect_ack(input int m, input int at, input bit rd, input logic [31:0] d);
        exp_t e;
        e.m = m; e.at = at; e.rd = rd; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic wait_acks(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            check_value("ack_timeout", 128'(exp_q.size()), 128'(0));
            exp_q.delete();
        end
    endtask

    // Requests stay high two more cycles (no second ack allowed), then drop
    // for one sampled cycle before the next transaction.
    task automatic finish_group();
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        req = '0;
        @(posedge clk); #1;
    endtask

    task automatic pulse_resp(input logic [NM-1:0] mask);
        resp = mask;
        @(posedge clk); #1;
        resp = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int base;
    logic [31:0] rd_exp [NM];

    initial begin
        rst = 1'b1; req = '0; cmd = '0; addr = '0; wdata = '0; resp = '0;
        repeat (3) @(posedge clk); #1;
        check_value("reset_ack", 128'(ack), 128'(0));
        check_value("reset_rdata", 128'(rdata), 128'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // Single write, then read it back
        base = cyc;
        drive(0, 1, 0, 32'h637);
        expect_ack(0, base + 1, 0, '0);
        wait_acks(10); finish_group();

        base = cyc;
        drive(0, 0, 0, $urandom);
        expect_ack(0, base + 1, 1, 32'h637);
        wait_acks(10); finish_group();
        check_value("hold_rdata0", 128'(rdata[0]), 128'(32'h637));
        pulse_resp(4'b0001);
        check_value("clear_rdata0", 128'(rdata[0]), 128'(0));

        // Two writers on slave 2
        base = cyc;
        drive(1, 1, 2, 32'h703);
        drive(2, 1, 2, 32'h5682);
        expect_ack(1, base + 1, 0, '0);
        expect_ack(2, base + 2, 0, '0);
        wait_acks(10); finish_group();

        // Two contended slaves in parallel
        base = cyc;
        drive(0, 1, 3, 32'h1212);
        drive(2, 1, 3, 32'h8901);
        drive(1, 1, 0, 32'h3434);
        drive(3, 1, 0, 32'h4672);
        expect_ack(0, base + 1, 0, '0);
        expect_ack(1, base + 1, 0, '0);
        expect_ack(2, base + 2, 0, '0);
        expect_ack(3, base + 2, 0, '0);
        wait_acks(10); finish_group();

        // Staggered contention; slave 3 pointer sits at 3 from the previous round
        base = cyc;
        drive(2, 1, 1, 32'h329038);
        drive(3, 1, 1, 32'h929102);
        expect_ack(2, base + 1, 0, '0);
        expect_ack(0, base + 2, 0, '0);
        expect_ack(3, base + 2, 0, '0);
        expect_ack(1, base + 3, 0, '0);
        @(posedge clk); #1;
        drive(0, 1, 3, 32'h181827);
        drive(1, 1, 3, 32'h6726);
        wait_acks(10); finish_group();

        // Parallel reads of all four slaves
        rd_exp[0] = 32'h4672; rd_exp[1] = 32'h5682;
        rd_exp[2] = 32'h6726; rd_exp[3] = 32'h929102;
        base = cyc;
        drive(0, 0, 0, $urandom);
        drive(1, 0, 2, $urandom);
        drive(2, 0, 3, $urandom);
        drive(3, 0, 1, $urandom);
        for (int m = 0; m < NM; m++) expect_ack(m, base + 1, 1, rd_exp[m]);
        wait_acks(10); finish_group();
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            for (int m = 0; m < NM; m++)
                check_value($sformatf("hold_rdata%0d", m), 128'(rdata[m]), 128'(rd_exp[m]));
        end
        pulse_resp(4'b0111);
        for (int m = 0; m < 3; m++)
            check_value($sformatf("clear_rdata%0d", m), 128'(rdata[m]), 128'(0));
        check_value("still_held_rdata3", 128'(rdata[3]), 128'(32'h929102));

        // Reset in the middle of contention on slave 2 (pointer at 2)
        base = cyc;
        drive(0, 1, 2, 32'hAAAA);
        drive(1, 1, 2, 32'hBBBB);
        drive(2, 1, 2, 32'hCCCC);
        expect_ack(2, base + 1, 0, '0);
        @(posedge clk);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check_value("async_reset_ack", 128'(ack), 128'(0));
        check_value("async_reset_rdata", 128'(rdata), 128'(0));
        check_value("pending_before_reset", 128'(exp_q.size()), 128'(0));
        exp_q.delete();
        req = '0;
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // All slave registers must be cleared
        base = cyc;
        for (int m = 0; m < NM; m++) begin
            drive(m, 0, m, $urandom);
            expect_ack(m, base + 1, 1, '0);
        end
        wait_acks(10); finish_group();
        pulse_resp(4'b1111);

        check_value("scoreboard_empty", 128'(exp_q.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
